// File: rtl/score_event_queue.sv
// score_event_queue
// Buffers collision hit events in a small FIFO and replays them to the score
// accumulator as single-cycle add pulses. Each pulse carries a BCD point value.
// A fixed idle gap after every pulse keeps requests from overlapping an add
// that is still in flight.
module score_event_queue #(
    parameter int DIGITS     = 4,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       clear,
    input  logic                       hit_valid,
    input  logic [1:0]                 hit_type,
    output logic                       add,
    output logic [DIGITS-1:0][3:0]     sum,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [GW-1:0]            gap_q, gap_d;
    logic [DIGITS-1:0][3:0]   sum_q, sum_d;
    logic                     overflow_q, overflow_d;
    logic [1:0]               mem_q [DEPTH];

    logic                     empty;
    logic                     full;
    logic                     pop_slot;
    logic                     pop;
    logic                     push;
    logic                     drop;

    // Only the 2-bit type is stored; the point value is derived when popped.
    function automatic logic [DIGITS-1:0][3:0] type_to_bcd(input logic [1:0] t);
        logic [DIGITS-1:0][3:0] v;
        v = '0;
        case (t)
            2'd0:    v[1] = 4'd2;   // large asteroid: 20
            2'd1:    v[1] = 4'd5;   // medium asteroid: 50
            2'd2:    v[2] = 4'd1;   // small asteroid: 100
            default: v[3] = 4'd1;   // saucer: 1000
        endcase
        return v;
    endfunction

    // Handshake decode. The pop decision uses the pre-push count, so a hit that
    // arrives at an empty queue is issued one cycle later. A full queue still
    // accepts a hit in a cycle where it also pops.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        pop_slot = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_q == GW'(1)));
        pop      = !clear && pop_slot && !empty;
        push     = !clear && hit_valid && (!full || pop);
        drop     = !clear && hit_valid && full && !pop;
    end

    // FIFO pointer, occupancy and sticky overflow next-state. Clear flushes them.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d    = count_q + CW'(push) - CW'(pop);
            overflow_d = overflow_q | drop;
        end
    end

    // Issue sequencer: IDLE -> ISSUE (one add cycle) -> GAP (GAP_CYCLES idle)
    // -> ISSUE again on the last gap cycle if work is waiting.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        sum_d   = sum_q;
        if (clear) begin
            state_d = ST_IDLE;
            gap_d   = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gap_d   = GW'(GAP_CYCLES);
                    state_d = ST_GAP;
                end
                ST_GAP: begin
                    gap_d = gap_q - GW'(1);
                    if (gap_q == GW'(1)) begin
                        state_d = pop ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end
            endcase
            // sum only moves on a pop, so it stays stable through ISSUE and GAP.
            if (pop) begin
                sum_d = type_to_bcd(mem_q[rd_ptr_q]);
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= hit_type;
        end
    end

    // Control and output registers; reset drops any in-flight pulse at once.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
        end
    end

    // The add pulse is decoded straight from the registered state.
    always_comb begin
        add      = (state_q == ST_ISSUE);
        sum      = sum_q;
        pending  = count_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_score_event_queue.sv
// Self-checking bench for score_event_queue: expected point values are queued
// as hits are driven and compared whenever the DUT raises add.
module tb_score_event_queue;

    localparam int DIGITS     = 4;
    localparam int DEPTH      = 4;
    localparam int GAP_CYCLES = 8;

    logic                   clk;
    logic                   resetN;
    logic                   clear;
    logic                   hit_valid;
    logic [1:0]             hit_type;
    logic                   add;
    logic [DIGITS-1:0][3:0] sum;
    logic [$clog2(DEPTH):0] pending;
    logic                   overflow;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q [$];
    int          add_count = 0;
    int          cyc       = 0;
    int          epoch     = 0;
    int          mon_epoch = 0;
    int          last_add  = -1;
    logic        prev_add  = 1'b0;

    score_event_queue #(
        .DIGITS    (DIGITS),
        .DEPTH     (DEPTH),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (clear),
        .hit_valid(hit_valid),
        .hit_type (hit_type),
        .add      (add),
        .sum      (sum),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd_of(input logic [1:0] t);
        case (t)
            2'd0:    return 16'h0020;
            2'd1:    return 16'h0050;
            2'd2:    return 16'h0100;
            default: return 16'h1000;
        endcase
    endfunction

    // Scoreboard monitor: every add pulse must match the oldest expected value,
    // last exactly one cycle, and follow the previous pulse by GAP_CYCLES+1.
    always @(negedge clk) begin
        if (epoch != mon_epoch) begin
            mon_epoch = epoch;
            last_add  = -1;
        end
        if (add === 1'b1) begin
            check_val("add_single", {31'd0, prev_add}, 32'd0);
            if (exp_q.size() == 0) begin
                check_val("add_unexpected", 32'd1, 32'd0);
            end else begin
                check_val("sum", {16'd0, sum}, {16'd0, exp_q.pop_front()});
            end
            if (last_add >= 0) begin
                check_val("spacing", cyc - last_add, GAP_CYCLES + 1);
            end
            last_add = cyc;
            add_count++;
            $display("add #%0d at cycle %0d sum=%04h pending=%0d", add_count, cyc, sum, pending);
        end
        prev_add = add;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drive one hit sampled at the next rising edge; accepted hits are expected.
    task automatic hit(input logic [1:0] t, input bit accepted);
        hit_valid = 1'b1;
        hit_type  = t;
        if (accepted) exp_q.push_back(bcd_of(t));
        step();
        hit_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetN    = 1'b0;
        clear     = 1'b0;
        hit_valid = 1'b0;
        step();
        step();
        exp_q.delete();
        epoch++;
        resetN = 1'b1;
    endtask

    initial begin
        int base;
        int max_pend;
        resetN    = 1'b0;
        clear     = 1'b0;
        hit_valid = 1'b0;
        hit_type  = 2'd0;
        step();
        step();
        check_val("rst_add", {31'd0, add}, 32'd0);
        check_val("rst_sum", {16'd0, sum}, 32'd0);
        check_val("rst_pending", {29'd0, pending}, 32'd0);
        check_val("rst_overflow", {31'd0, overflow}, 32'd0);
        resetN = 1'b1;

        // Single hit: 2-clock latency, one pulse, sum holds afterwards.
        base = add_count;
        hit(2'd2, 1'b1);
        check_val("single_pend1", {29'd0, pending}, 32'd1);
        check_val("single_add_early", {31'd0, add}, 32'd0);
        step();
        check_val("single_add", {31'd0, add}, 32'd1);
        check_val("single_sum", {16'd0, sum}, 32'h0100);
        check_val("single_pend0", {29'd0, pending}, 32'd0);
        repeat (12) step();
        check_val("single_sum_hold", {16'd0, sum}, 32'h0100);
        check_val("single_count", add_count - base, 32'd1);
        $display("single hit done");

        // Burst of three consecutive hits.
        do_reset();
        base = add_count;
        hit(2'd0, 1'b1);
        hit(2'd1, 1'b1);
        hit(2'd3, 1'b1);
        max_pend = int'(pending);
        for (int i = 0; i < 40; i++) begin
            step();
            if (int'(pending) > max_pend) max_pend = int'(pending);
        end
        check_val("burst_peak", max_pend, 32'd2);
        check_val("burst_count", add_count - base, 32'd3);
        check_val("burst_overflow", {31'd0, overflow}, 32'd0);
        $display("burst done");

        // Overflow: six back-to-back hits, the sixth is dropped.
        do_reset();
        base = add_count;
        for (int i = 0; i < 5; i++) hit(2'd0, 1'b1);
        check_val("ovf_before", {31'd0, overflow}, 32'd0);
        check_val("ovf_full", {29'd0, pending}, 32'd4);
        hit(2'd0, 1'b0);
        check_val("ovf_set", {31'd0, overflow}, 32'd1);
        check_val("ovf_pend", {29'd0, pending}, 32'd4);
        repeat (60) step();
        check_val("ovf_count", add_count - base, 32'd5);
        check_val("ovf_sticky", {31'd0, overflow}, 32'd1);
        check_val("ovf_drained", {29'd0, pending}, 32'd0);
        $display("overflow done");

        // Clear during the first GAP with a concurrent hit (overflow still set).
        epoch++;
        base = add_count;
        hit(2'd1, 1'b1);
        hit(2'd1, 1'b1);
        hit(2'd1, 1'b1);
        step();
        clear     = 1'b1;
        hit_valid = 1'b1;
        hit_type  = 2'd3;
        step();
        clear     = 1'b0;
        hit_valid = 1'b0;
        exp_q.delete();
        check_val("clr_pending", {29'd0, pending}, 32'd0);
        check_val("clr_sum", {16'd0, sum}, 32'd0);
        check_val("clr_overflow", {31'd0, overflow}, 32'd0);
        check_val("clr_add", {31'd0, add}, 32'd0);
        repeat (40) step();
        check_val("clr_count", add_count - base, 32'd1);
        check_val("clr_pend_after", {29'd0, pending}, 32'd0);
        $display("clear done");

        // Push into a full FIFO in the cycle of a GAP->ISSUE pop.
        do_reset();
        base = add_count;
        hit(2'd0, 1'b1);
        hit(2'd1, 1'b1);
        hit(2'd2, 1'b1);
        hit(2'd3, 1'b1);
        hit(2'd0, 1'b1);
        repeat (5) step();
        check_val("full_pend", {29'd0, pending}, 32'd4);
        check_val("full_add_idle", {31'd0, add}, 32'd0);
        hit(2'd2, 1'b1);
        check_val("full_add", {31'd0, add}, 32'd1);
        check_val("full_pend_keep", {29'd0, pending}, 32'd4);
        check_val("full_no_ovf", {31'd0, overflow}, 32'd0);
        repeat (60) step();
        check_val("full_count", add_count - base, 32'd6);
        check_val("full_no_ovf_end", {31'd0, overflow}, 32'd0);
        $display("push/pop at full done");

        // Asynchronous reset while add is high.
        do_reset();
        hit(2'd3, 1'b1);
        hit(2'd1, 1'b1);
        check_val("ar_add_hi", {31'd0, add}, 32'd1);
        check_val("ar_pend", {29'd0, pending}, 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        check_val("ar_add", {31'd0, add}, 32'd0);
        check_val("ar_sum", {16'd0, sum}, 32'd0);
        check_val("ar_pending", {29'd0, pending}, 32'd0);
        check_val("ar_overflow", {31'd0, overflow}, 32'd0);
        exp_q.delete();
        epoch++;
        step();
        step();
        resetN = 1'b1;
        base = add_count;
        repeat (20) step();
        check_val("ar_no_add", add_count - base, 32'd0);
        check_val("ar_empty", {29'd0, pending}, 32'd0);
        $display("async reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_event_queue.md
# score_event_queue

Upstream feeder for the score accumulator. It converts asteroid/saucer hit events from the collision logic into BCD point values and buffers them in a small FIFO. It replays them to the accumulator as single-cycle `add` pulses with a stable BCD `sum`. Pulses are spaced far enough apart that none lands while the accumulator's BCD adder is still busy. Without this spacing, simultaneous or back-to-back hits would be silently lost.

## Interface
Parameters:
- `DIGITS`, default 4: BCD digits of `sum`. Must be ≥ 4.
- `DEPTH`, default 4: FIFO entries. Power of two, ≥ 2.
- `GAP_CYCLES`, default 8: idle cycles enforced after each `add` pulse. Must be ≥ accumulator add latency + 1.

Ports (clock and reset first):
- `clk` input 1: single system clock, rising edge.
- `resetN` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous flush at new game. Empties FIFO, aborts any issue, clears `overflow`.
- `hit_valid` input 1: one hit event this cycle.
- `hit_type` input 2: 0 = large asteroid (20), 1 = medium asteroid (50), 2 = small asteroid (100), 3 = saucer (1000).
- `add` output 1: single-cycle request to the accumulator.
- `sum` output `[DIGITS-1:0][3:0]`: BCD points for the current/last request. Digit 0 is ones.
- `pending` output `$clog2(DEPTH)+1`: number of events queued, excluding the one being issued.
- `overflow` output 1: sticky. Set when an event was dropped.

## Operation
- Reset: `add`=0, `sum`=0, `pending`=0, `overflow`=0, FIFO empty, state IDLE, gap counter 0.
- Push: `hit_valid`=1 and FIFO not full writes the 2-bit `hit_type` at the write pointer.
- Full: if FIFO is full at a push, the event is dropped and `overflow` is set. FIFO contents are unchanged.
- Type-to-BCD mapping is fixed and only applied on pop:
  - 0 → digits 0020
  - 1 → 0050
  - 2 → 0100
  - 3 → 1000
  - Higher digits are 0.
- State machine:
  - IDLE: if FIFO is not empty, pop the head, register `sum`=value(head), `add`=1, go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle, `add`=1): load gap counter with GAP_CYCLES, go to GAP.
  - GAP (`add`=0): decrement the counter. On the last gap cycle (counter==1), behave as IDLE: pop and go to ISSUE if not empty, else go to IDLE.
- `sum` holds its value from ISSUE until the next pop. It is never changed during GAP.
- Simultaneous push and pop in the same cycle is legal:
  - count is unchanged;
  - a push into a full FIFO while a pop occurs that cycle succeeds, with no overflow.
- Simultaneous push into an empty FIFO and IDLE pop check: the pop sees the pre-push (empty) state. The event is issued the following cycle.
- `clear` has priority over push, pop and state transitions:
  - next cycle: FIFO empty, `pending`=0, `overflow`=0, state IDLE, `add`=0, `sum`=0;
  - a `hit_valid` in the same cycle as `clear` is discarded.
- Asynchronous `resetN` assertion mid-GAP or mid-ISSUE returns everything to reset values immediately. No partial pulse persists.
- Pointer wrap: read/write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full and empty are distinguished by the count.

## Timing
- Event sampled at rising edge k (empty queue, IDLE): `pending`=1 after k, pop at edge k+1, `add`=1 for the cycle after edge k+1. Latency is 2 clocks.
- `add` is high for exactly one cycle per event.
- With backlog, consecutive `add` pulses are exactly GAP_CYCLES+1 cycles apart (rising-edge to rising-edge).
- Throughput: one event per GAP_CYCLES+1 cycles. Sustained faster arrivals fill the FIFO and set `overflow`.
- `pending` and `overflow` are registered outputs, updated on the same edge as the FIFO.

## Test plan
- Single hit: reset, `hit_type`=2 for one cycle. Required: `add` pulses once, 2 clocks later, with `sum`=0100. `sum` stays 0100 afterwards. `pending` goes 1 then 0.
- Burst spacing: 3 hits (types 0, 1, 3) on consecutive cycles, default parameters. Required:
  - `add` pulses with `sum` 0020, 0050, 1000, in order;
  - pulses 9 cycles apart;
  - `pending` peaks at 2;
  - `overflow`=0.
- Overflow: 6 back-to-back hits of type 0, DEPTH=4. Required:
  - 5 adds total (1 issued immediately plus 4 buffered);
  - `overflow`=1 after the 6th push;
  - all sums 0020.
- Push/pop at full: FIFO full, new hit in the cycle of a GAP→ISSUE pop. Required: hit accepted, `overflow` stays 0, `pending` stays 4.
- Clear mid-GAP: 3 hits queued, assert `clear` during the first GAP with a concurrent `hit_valid`. Required:
  - next cycle `pending`=0, `sum`=0, `overflow`=0;
  - no further `add` pulses.
- Async reset mid-ISSUE: drop `resetN` while `add`=1. Required: `add`=0 immediately, all outputs at reset values, queue empty after release.
